// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_pkg
// Description : Shared constants and helpers for param_updown_counter.
//               MODE_WRAP / MODE_SAT select boundary behaviour; clamp_load
//               limits a load value to the terminal count.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Returns value, limited to max (unsigned compare).
  function automatic logic [31:0] clamp_load(input logic [31:0] value,
                                             input logic [31:0] max);
    return (value > max) ? max : value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/counter_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : counter_prescaler
// Description : Enable prescaler. Advances 0..PRESCALE-1 on cycles with en=1
//               and issues tick on the enabled cycle at PRESCALE-1, wrapping
//               back to 0. Holds when en=0. PRESCALE=1 gives tick=en.
// Ports       : clk   - clock, rising edge
//               reset - asynchronous active-high reset
//               clr   - synchronous clear of the phase counter
//               en    - count enable
//               tick  - combinational step strobe
// Revision    : 1.0 - initial release
// ============================================================================
module counter_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  // With PRESCALE=1 this register stays at 0 and LAST is 0, so tick=en.
  logic [CW-1:0] phase;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (en) begin
      if (phase == LAST) phase <= '0;
      else               phase <= phase + CW'(1);
    end
  end

  assign tick = en && (phase == LAST);

endmodule
`default_nettype wire

// File: rtl/param_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : param_updown_counter
// Description : Parametrised up/down event counter with load, clear, enable
//               prescaler, wrap or saturate boundary mode, one-cycle terminal
//               count pulse and sticky overflow/underflow flags.
// Ports       : clk       - clock, rising edge
//               reset     - asynchronous active-high reset
//               clear     - synchronous clear of count, prescaler, flags
//               load      - synchronous load of load_data (clamped to MAX_VAL)
//               load_data - value to load
//               en        - count enable into the prescaler
//               dir       - 1 = up, 0 = down (sampled on tick only)
//               out_en    - gate for count_out
//               count     - raw counter register
//               count_out - count when out_en=1, else zero
//               tc        - one-cycle pulse after each boundary tick
//               ovf       - sticky: up-count attempted at MAX_VAL
//               udf       - sticky: down-count attempted at 0
// Revision    : 1.0 - initial release
// ============================================================================
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH    = 8,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter int              MODE     = MODE_WRAP,
  parameter int              PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             en,
  input  logic             dir,
  input  logic             out_en,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_out,
  output logic             tc,
  output logic             ovf,
  output logic             udf
);

  localparam logic [WIDTH-1:0] MAX = MAX_VAL[WIDTH-1:0];

  logic             tick;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic             ovf_nxt;
  logic             udf_nxt;

  // Load also restarts the prescaler so the next step needs a full period.
  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (clear | load),
    .en    (en),
    .tick  (tick)
  );

  always_comb begin
    count_nxt = count;
    tc_nxt    = 1'b0;
    ovf_nxt   = ovf;
    udf_nxt   = udf;
    if (clear) begin
      count_nxt = '0;
      ovf_nxt   = 1'b0;
      udf_nxt   = 1'b0;
    end else if (load) begin
      count_nxt = WIDTH'(clamp_load(32'(load_data), 32'(MAX)));
    end else if (tick) begin
      if (dir) begin
        if (count == MAX) begin
          tc_nxt    = 1'b1;
          ovf_nxt   = 1'b1;
          count_nxt = (MODE == MODE_SAT) ? MAX : '0;
        end else begin
          count_nxt = count + WIDTH'(1);
        end
      end else begin
        if (count == '0) begin
          tc_nxt    = 1'b1;
          udf_nxt   = 1'b1;
          count_nxt = (MODE == MODE_SAT) ? '0 : MAX;
        end else begin
          count_nxt = count - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      count <= count_nxt;
      tc    <= tc_nxt;
      ovf   <= ovf_nxt;
      udf   <= udf_nxt;
    end
  end

  assign count_out = out_en ? count : '0;

endmodule
`default_nettype wire

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
- Parametrised successor to the 8-bit load/count/output-enable counter. Adds:
  - configurable width and terminal value;
  - up/down direction;
  - wrap or saturate mode;
  - an enable prescaler;
  - a terminal-count pulse and sticky overflow/underflow flags.
- Used as a generic event/timebase counter inside the top-level wrapper. The wrapper maps pins onto its ports.

Parameters:
- WIDTH, 8: counter width in bits. Legal range 2..32.
- MAX_VAL, 2**WIDTH-1: terminal (highest) count value. Must satisfy 1 <= MAX_VAL <= 2**WIDTH-1.
- MODE, MODE_WRAP: boundary behaviour, MODE_WRAP or MODE_SAT (from the package).
- PRESCALE, 1: number of enabled cycles per count step. Must be >= 1.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous clear of count, prescaler and sticky flags.
- load  input  1  synchronous load of load_data.
- load_data  input  WIDTH  value to load.
- en  input  1  count enable; feeds the prescaler.
- dir  input  1  1 = count up, 0 = count down.
- out_en  input  1  output gate for count_out.
- count  output  WIDTH  raw counter register.
- count_out  output  WIDTH  count when out_en=1, else all zeros. Combinational; no tri-state inside the block.
- tc  output  1  one-cycle terminal-count pulse.
- ovf  output  1  sticky: an up-count was attempted at MAX_VAL.
- udf  output  1  sticky: a down-count was attempted at 0.

Behaviour:
- Reset (asynchronous, immediate): count=0, prescaler=0, tc=0, ovf=0, udf=0. count_out=0 regardless of out_en.
- Reset asserted mid-operation aborts any pending tick; no tc is produced for it.
- Priority per rising edge: reset > clear > load > tick > hold.
- clear:
  - count<=0, prescaler<=0, tc<=0, ovf<=0, udf<=0.
  - en, load and dir are ignored that cycle.
- load:
  - count <= min(load_data, MAX_VAL); out-of-range loads clamp to MAX_VAL.
  - prescaler<=0, tc<=0; sticky flags unchanged.
  - A tick coinciding with load is discarded.
- Prescaler:
  - Counts 0..PRESCALE-1 only on cycles with en=1; holds when en=0.
  - tick = en && (prescaler == PRESCALE-1). The prescaler wraps to 0 on tick.
  - PRESCALE=1 gives tick=en.
- Step on tick, up (dir=1):
  - count<MAX_VAL: count+1.
  - count==MAX_VAL: WRAP gives count<=0; SAT holds at MAX_VAL. In both modes tc is asserted the following cycle and ovf<=1.
- Step on tick, down (dir=0):
  - count>0: count-1.
  - count==0: WRAP gives count<=MAX_VAL; SAT holds at 0. In both modes tc is asserted the following cycle and udf<=1.
- tc:
  - Registered; high for exactly one cycle after each boundary tick. Otherwise 0.
  - In SAT mode, repeated ticks at the boundary produce repeated tc pulses, one per tick.
- dir is sampled only on tick cycles. Changing dir between ticks has no other effect.
- Arithmetic is WIDTH bits, unsigned. No intermediate value exceeds MAX_VAL or goes below 0.
- Latency: count, tc and the flags update on the edge at which tick/load/clear is sampled. count_out follows count and out_en combinationally.

Decomposition:
- Shared package counter_pkg holds:
  - mode constants MODE_WRAP=0 and MODE_SAT=1;
  - a function clamp_load(value, max).
- Natural sub-module: counter_prescaler.
  - Parameter: PRESCALE.
  - Ports: clk, reset, clr, en, tick.
  - clr is driven by clear|load.
- The top module holds the count register, the boundary logic, tc, and the sticky flags.

Test Plan (WIDTH=8, MAX_VAL=9 unless noted):
- Reset and gating: assert reset with out_en=1 -> count=0, count_out=0, tc=0, ovf=0, udf=0. Release, en=1, dir=1, 3 cycles -> count=3. Drop out_en -> count_out=0, count still 3.
- Wrap up/down (MODE_WRAP, PRESCALE=1):
  - Load 8, en=1, dir=1 -> count 9, then 0. tc high the cycle after 9->0; ovf=1.
  - Then dir=0 -> count 9 (wrap from 0). tc pulses again; udf=1.
- Saturate (MODE_SAT): load 7, en=1, dir=1 for 5 cycles -> count 8,9,9,9,9. tc pulses on each of the last three ticks; ovf=1. clear -> count=0, ovf=0, tc=0.
- Prescaler (PRESCALE=4):
  - en=1 for 8 cycles -> count advances only on the 4th and 8th; count=2.
  - en=0 for 5 cycles, then en=1 for 2 cycles -> still 2 (prescaler held at 2 after those 2 cycles, not reset).
- Priority and clamp:
  - load=1 with load_data=200 -> count=9 (clamped).
  - Same cycle load=1, en=1, tick due -> count=load value with no extra step.
  - clear=1 and load=1 together -> count=0.
- Async reset mid-run: with count=5 and prescaler=2, assert reset between clock edges -> count, tc and flags go to 0 immediately, before the next edge. The first tick after release needs a full PRESCALE cycles.
